// File: rtl/alu32.sv
// Registered 32-bit ALU: combinational compute, single output register with status flags.
// Optional multiplier (MUL/MULHU) is compiled in only when ALU_MUL_EN is defined.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_NAND = 5'd6,  OP_XNOR = 5'd7,
    OP_NOT  = 5'd8,  OP_SLL  = 5'd9,  OP_SRL  = 5'd10, OP_SRA  = 5'd11,
    OP_ROL  = 5'd12, OP_ROR  = 5'd13, OP_SLT  = 5'd14, OP_SLTU = 5'd15,
    OP_INC  = 5'd16, OP_DEC  = 5'd17, OP_NEG  = 5'd18, OP_PASA = 5'd19,
    OP_PASB = 5'd20, OP_EQ   = 5'd21, OP_MIN  = 5'd22, OP_MAX  = 5'd23,
    OP_MINU = 5'd24, OP_MAXU = 5'd25, OP_CLZ  = 5'd26, OP_POPC = 5'd27,
    OP_MUL  = 5'd28, OP_MULH = 5'd29
  } op_e;

  logic [WIDTH-1:0]   w_x, w_y, w_res;
  logic               w_cin, w_arith, w_carry, w_ovf, w_ill;
  logic [WIDTH:0]     w_sum;
  logic [SW-1:0]      w_sh;
  logic [2*WIDTH-1:0] w_rol2, w_ror2;
  logic [CW-1:0]      w_clz, w_pop;
  logic               w_slt, w_sltu;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] w_prod;
  assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  assign w_sh   = b[SW-1:0];
  assign w_rol2 = {a, a} << w_sh;
  assign w_ror2 = {a, a} >> w_sh;
  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

  // All add/subtract forms share one adder as x + y + cin (subtraction uses ~y, cin=1).
  always_comb begin
    w_x     = a;
    w_y     = b;
    w_cin   = 1'b0;
    w_arith = 1'b1;
    case (opcode)
      OP_ADD:  ;
      OP_SUB:  begin w_y = ~b;                  w_cin = 1'b1; end
      OP_INC:  begin w_y = '0;                  w_cin = 1'b1; end
      OP_DEC:  begin w_y = ~WIDTH'(1);          w_cin = 1'b1; end
      OP_NEG:  begin w_x = '0;     w_y = ~a;    w_cin = 1'b1; end
      default: w_arith = 1'b0;
    endcase
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  end

  always_comb begin
    w_clz = CW'(WIDTH);
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) w_clz = CW'(WIDTH - 1 - i);
      w_pop = w_pop + {{(CW-1){1'b0}}, a[i]};
    end
  end

  always_comb begin
    w_res   = '0;
    w_ill   = 1'b0;
    w_carry = w_arith & w_sum[WIDTH];
    w_ovf   = w_arith & (w_x[WIDTH-1] == w_y[WIDTH-1]) & (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    case (opcode)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: w_res = w_sum[WIDTH-1:0];
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOR:  w_res = ~(a | b);
      OP_NAND: w_res = ~(a & b);
      OP_XNOR: w_res = ~(a ^ b);
      OP_NOT:  w_res = ~a;
      OP_SLL:  w_res = a << w_sh;
      OP_SRL:  w_res = a >> w_sh;
      OP_SRA:  w_res = $unsigned($signed(a) >>> w_sh);
      OP_ROL:  w_res = w_rol2[2*WIDTH-1:WIDTH];
      OP_ROR:  w_res = w_ror2[WIDTH-1:0];
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_PASA: w_res = a;
      OP_PASB: w_res = b;
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_MIN:  w_res = w_slt  ? a : b;
      OP_MAX:  w_res = w_slt  ? b : a;
      OP_MINU: w_res = w_sltu ? a : b;
      OP_MAXU: w_res = w_sltu ? b : a;
      OP_CLZ:  w_res = {{(WIDTH-CW){1'b0}}, w_clz};
      OP_POPC: w_res = {{(WIDTH-CW){1'b0}}, w_pop};
`ifdef ALU_MUL_EN
      OP_MUL:  w_res = w_prod[WIDTH-1:0];
      OP_MULH: w_res = w_prod[2*WIDTH-1:WIDTH];
`endif
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= enable;
      if (enable) begin
        out      <= w_res;
        zero     <= (w_res == '0);
        negative <= w_res[WIDTH-1];
        carry    <= w_carry;
        overflow <= w_ovf;
        illegal  <= w_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: stimulus pushes expected results, a monitor pops on out_valid.
module tb_alu32;

  typedef struct packed {
    logic [31:0] o;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic        il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  opcode = '0;
  logic [31:0] a = '0, b = '0;
  logic        enable = 1'b0;
  logic [31:0] out;
  logic        out_valid, zero, negative, carry, overflow, illegal;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t mon_last = '0;

  alu32 dut (
    .clk(clk), .rst(rst), .opcode(opcode), .a(a), .b(b), .enable(enable),
    .out(out), .out_valid(out_valid), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, "_out"},  out,             e.o);
    chk({tag, "_zero"}, 32'(zero),       32'(e.z));
    chk({tag, "_neg"},  32'(negative),   32'(e.n));
    chk({tag, "_cy"},   32'(carry),      32'(e.c));
    chk({tag, "_ovf"},  32'(overflow),   32'(e.v));
    chk({tag, "_ill"},  32'(illegal),    32'(e.il));
  endtask

  function automatic bit ovf32(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  function automatic exp_t mk(input logic [31:0] r, input logic c, input logic v, input logic il);
    exp_t e;
    e.o = r; e.z = (r == 0); e.n = r[31]; e.c = c; e.v = v; e.il = il;
    return e;
  endfunction

  // Reference model: plain wide arithmetic on signed/unsigned 64-bit values.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r = '0;
    logic c = 1'b0, v = 1'b0, il = 1'b0;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    int sh = int'(y[4:0]);
    logic [63:0] p;
    int n;
    case (op)
      5'd0:  begin r = x + y; c = (ux + uy) > 64'sd4294967295; v = ovf32(sx + sy); end
      5'd1:  begin r = x - y; c = (ux >= uy); v = ovf32(sx - sy); end
      5'd2:  r = x & y;
      5'd3:  r = x | y;
      5'd4:  r = x ^ y;
      5'd5:  r = ~(x | y);
      5'd6:  r = ~(x & y);
      5'd7:  r = ~(x ^ y);
      5'd8:  r = ~x;
      5'd9:  r = x << sh;
      5'd10: r = x >> sh;
      5'd11: r = 32'(sx >>> sh);
      5'd12: r = (sh == 0) ? x : ((x << sh) | (x >> (32 - sh)));
      5'd13: r = (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
      5'd14: r = (sx < sy) ? 32'd1 : 32'd0;
      5'd15: r = (ux < uy) ? 32'd1 : 32'd0;
      5'd16: begin r = x + 1; c = (x == 32'hFFFF_FFFF); v = ovf32(sx + 1); end
      5'd17: begin r = x - 1; c = (x != 0); v = ovf32(sx - 1); end
      5'd18: begin r = 32'd0 - x; c = (x == 0); v = ovf32(-sx); end
      5'd19: r = x;
      5'd20: r = y;
      5'd21: r = (x == y) ? 32'd1 : 32'd0;
      5'd22: r = (sx < sy) ? x : y;
      5'd23: r = (sx > sy) ? x : y;
      5'd24: r = (ux < uy) ? x : y;
      5'd25: r = (ux > uy) ? x : y;
      5'd26: begin
        n = 0;
        for (int i = 31; i >= 0; i--) begin
          if (x[i]) break;
          n++;
        end
        r = 32'(n);
      end
      5'd27: r = 32'($countones(x));
`ifdef ALU_MUL_EN
      5'd28: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
      5'd29: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
`endif
      default: il = 1'b1;
    endcase
    return mk(r, c, v, il);
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic en);
    @(negedge clk);
    opcode = op; a = x; b = y; enable = en;
    if (en) q.push_back(model(op, x, y));
  endtask

  task automatic issue_exp(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                           input exp_t e);
    @(negedge clk);
    opcode = op; a = x; b = y; enable = 1'b1;
    q.push_back(e);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop on every valid output; otherwise outputs must hold their last capture.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst) mon_last = '0;
      else if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          cmp("cap", e);
          mon_last = e;
        end
      end else cmp("hold", mon_last);
    end
  end

  initial begin
    #1;
    cmp("rst0", '0);
    chk("rst0_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue_exp(5'd0,  32'h0F0F_0F0F, 32'h70F0_F0F0, mk(32'h7FFF_FFFF, 0, 0, 0));
    issue_exp(5'd0,  32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0, 1, 0));
    issue_exp(5'd1,  32'h0000_0000, 32'h0000_0001, mk(32'hFFFF_FFFF, 0, 0, 0));
    issue_exp(5'd0,  32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1, 0, 0));
    issue_exp(5'd18, 32'h8000_0000, 32'h0000_0000, mk(32'h8000_0000, 0, 1, 0));
    issue_exp(5'd17, 32'h0000_0000, 32'h0000_0000, mk(32'hFFFF_FFFF, 0, 0, 0));
    issue_exp(5'd11, 32'h8000_0000, 32'h0000_0004, mk(32'hF800_0000, 0, 0, 0));
    issue_exp(5'd13, 32'h0000_0001, 32'h0000_0001, mk(32'h8000_0000, 0, 0, 0));
    issue_exp(5'd9,  32'h0000_0001, 32'h0000_0025, mk(32'h0000_0020, 0, 0, 0));
    issue_exp(5'd26, 32'h0000_0000, 32'h0000_0000, mk(32'd32, 0, 0, 0));
    issue_exp(5'd27, 32'hFFFF_FFFF, 32'h0000_0000, mk(32'd32, 0, 0, 0));
    issue_exp(5'd14, 32'hFFFF_FFFF, 32'h0000_0000, mk(32'd1, 0, 0, 0));
    issue_exp(5'd15, 32'hFFFF_FFFF, 32'h0000_0000, mk(32'd0, 0, 0, 0));
    issue_exp(5'd31, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'd0, 0, 0, 1));
`ifdef ALU_MUL_EN
    issue_exp(5'd28, 32'd3, 32'd5, mk(32'd15, 0, 0, 0));
`else
    issue_exp(5'd28, 32'd3, 32'd5, mk(32'd0, 0, 0, 1));
`endif
    issue(5'd0, 32'd5, 32'd6, 1'b1);
    issue(5'd4, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0);

    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    cmp("rst_async", '0);
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    opcode = 5'd0; a = 32'd7; b = 32'd8; enable = 1'b1;
    @(posedge clk); #1;
    chk("rst_override_out", out, 32'd0);
    chk("rst_override_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 400; i++)
      issue(5'($urandom_range(0, 31)), pick(), pick(), ($urandom_range(0, 4) != 0));

    issue(5'd0, 32'd0, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
